nucleic_acid_sequencer: RTL and testbench

- Protocol controller that drives the shared pneumatic control lines of the nucleic_acid_11 reactor array.
- Sequences one extraction run: sample load, peristaltic mix, bead capture, N washes, elution, collection.
- Sits between the host/timing logic and the solenoid driver bank. All eleven reactors share every control line, so one sequencer runs the whole array in lock-step.

---
 rtl/nucleic_acid_pkg.sv | 72 +++++++
 rtl/nucleic_acid_sequencer_if.sv | 33 +++
 rtl/nucleic_acid_sequencer_pump_phase_gen.sv | 44 ++++
 rtl/nucleic_acid_sequencer.sv | 133 +++++++++++++
 tb/tb_nucleic_acid_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nucleic_acid_pkg.sv
// rtl/nucleic_acid_pkg.sv - shared phase encodings, valve vector and pump pattern for the sequencer
package nucleic_acid_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_LOAD    = 3'd1,
        PH_MIX     = 3'd2,
        PH_CAPTURE = 3'd3,
        PH_WASH    = 3'd4,
        PH_SETTLE  = 3'd5,
        PH_ELUTE   = 3'd6,
        PH_COLLECT = 3'd7
    } phase_e;

    typedef struct packed {
        logic lysis;
        logic wash;
        logic elute;
        logic horiz;
        logic vertical;
        logic loop_exit;
        logic bead_vtl;
        logic bead_trap;
        logic collection;
        logic dead_end;
        logic pump1;
        logic pump2;
        logic pump3;
    } valve_vec_t;

    localparam logic [2:0] PUMP_SEQ [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    // Static valve openings per phase; pump lines are filled in by the pump generator.
    function automatic valve_vec_t valve_pattern(input phase_e p);
        valve_vec_t v;
        v = '0;
        case (p)
            PH_LOAD: begin
                v.lysis    = 1'b1;
                v.vertical = 1'b1;
                v.horiz    = 1'b1;
            end
            PH_MIX: v.vertical = 1'b1;
            PH_CAPTURE: begin
                v.bead_vtl  = 1'b1;
                v.bead_trap = 1'b1;
                v.loop_exit = 1'b1;
                v.dead_end  = 1'b1;
            end
            PH_WASH: begin
                v.wash      = 1'b1;
                v.vertical  = 1'b1;
                v.loop_exit = 1'b1;
                v.bead_trap = 1'b1;
            end
            PH_ELUTE: begin
                v.elute     = 1'b1;
                v.vertical  = 1'b1;
                v.loop_exit = 1'b1;
                v.bead_trap = 1'b1;
            end
            PH_COLLECT: begin
                v.collection = 1'b1;
                v.loop_exit  = 1'b1;
                v.bead_trap  = 1'b1;
            end
            default: ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/nucleic_acid_sequencer_if.sv
// rtl/nucleic_acid_sequencer_if.sv - host/config and valve-bank signal bundle for the sequencer
interface nucleic_acid_sequencer_if #(parameter int T_W = 16);
    logic           start;
    logic           abort;
    logic [T_W-1:0] load_time;
    logic [7:0]     mix_cycles;
    logic [T_W-1:0] wash_time;
    logic [3:0]     wash_reps;
    logic [T_W-1:0] elute_time;
    logic           busy;
    logic           done;
    logic           aborted;
    logic [2:0]     phase;
    logic           lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl;
    logic           loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, dead_end_ctl;
    logic           pump1, pump2, pump3;

    modport master (
        output start, abort, load_time, mix_cycles, wash_time, wash_reps, elute_time,
        input  busy, done, aborted, phase,
        input  lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
        input  loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, dead_end_ctl,
        input  pump1, pump2, pump3
    );

    modport slave (
        input  start, abort, load_time, mix_cycles, wash_time, wash_reps, elute_time,
        output busy, done, aborted, phase,
        output lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
        output loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, dead_end_ctl,
        output pump1, pump2, pump3
    );
endinterface

// File: rtl/nucleic_acid_sequencer_pump_phase_gen.sv
// rtl/nucleic_acid_sequencer_pump_phase_gen.sv - 6-step peristaltic pump pattern with per-cycle strobe
module pump_phase_gen
    import nucleic_acid_pkg::*;
#(
    parameter int STEP_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    output logic [2:0] pattern,
    output logic       cycle_done
);
    localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(STEP_TICKS - 1);

    logic [CW-1:0] tick;
    logic [2:0]    idx;
    logic          active;
    logic          step_end;

    assign active   = enable && !clear;
    assign step_end = (tick == LAST_TICK);
    // Pattern for the upcoming cycle; the sequencer registers it with the other valves.
    assign pattern  = active ? PUMP_SEQ[idx] : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick       <= '0;
            idx        <= '0;
            cycle_done <= 1'b0;
        end else if (!active) begin
            tick       <= '0;
            idx        <= '0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= step_end && (idx == 3'd5);
            tick       <= step_end ? '0 : tick + CW'(1);
            if (step_end) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
        end
    end
endmodule

// File: rtl/nucleic_acid_sequencer.sv
// rtl/nucleic_acid_sequencer.sv - lock-step extraction protocol controller for the reactor array
module nucleic_acid_sequencer
    import nucleic_acid_pkg::*;
#(
    parameter int T_W           = 16,
    parameter int STEP_TICKS    = 4,
    parameter int CAPTURE_TICKS = 64,
    parameter int COLLECT_TICKS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    nucleic_acid_sequencer_if.slave bus
);
    phase_e         state, state_next;
    logic [T_W-1:0] timer, entry_dur, wash_time_q, elute_time_q;
    logic [7:0]     mix_left;
    logic [3:0]     reps_left;
    logic           timer_end, cycle_done, pump_en;
    logic [2:0]     pump_pat;
    valve_vec_t     valves_next, valves_q;
    logic           busy_next, done_next, aborted_next;
    logic           busy_q, done_q, aborted_q;

    assign timer_end = (timer == T_W'(1));
    assign pump_en   = (state_next == PH_MIX);

    pump_phase_gen #(.STEP_TICKS(STEP_TICKS)) u_pump (
        .clk       (clk),
        .rst       (rst),
        .enable    (pump_en),
        .clear     (!pump_en),
        .pattern   (pump_pat),
        .cycle_done(cycle_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PH_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PH_IDLE:    if (bus.start && !bus.abort) state_next = PH_LOAD;
            PH_LOAD:    if (timer_end) state_next = (mix_left != 8'd0) ? PH_MIX : PH_CAPTURE;
            PH_MIX:     if (cycle_done && mix_left == 8'd1) state_next = PH_CAPTURE;
            PH_CAPTURE: if (timer_end) state_next = (reps_left != 4'd0) ? PH_WASH : PH_ELUTE;
            PH_WASH:    if (timer_end) state_next = PH_SETTLE;
            PH_SETTLE:  state_next = (reps_left == 4'd1) ? PH_ELUTE : PH_WASH;
            PH_ELUTE:   if (timer_end) state_next = PH_COLLECT;
            PH_COLLECT: if (timer_end) state_next = PH_IDLE;
            default:    state_next = PH_IDLE;
        endcase
        if (state != PH_IDLE && bus.abort) state_next = PH_IDLE;
    end

    // Duration loaded into the phase timer on entry; zero is stretched to one cycle.
    always_comb begin
        entry_dur = T_W'(1);
        case (state_next)
            PH_LOAD:    entry_dur = bus.load_time;
            PH_CAPTURE: entry_dur = T_W'(CAPTURE_TICKS);
            PH_WASH:    entry_dur = wash_time_q;
            PH_ELUTE:   entry_dur = elute_time_q;
            PH_COLLECT: entry_dur = T_W'(COLLECT_TICKS);
            default:    ;
        endcase
        if (entry_dur == '0) entry_dur = T_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer        <= '0;
            wash_time_q  <= '0;
            elute_time_q <= '0;
            mix_left     <= '0;
            reps_left    <= '0;
        end else begin
            if (state_next != state)   timer <= entry_dur;
            else if (timer > T_W'(1))  timer <= timer - T_W'(1);
            if (state == PH_IDLE && state_next == PH_LOAD) begin
                wash_time_q  <= bus.wash_time;
                elute_time_q <= bus.elute_time;
                mix_left     <= bus.mix_cycles;
                reps_left    <= bus.wash_reps;
            end
            if (state == PH_MIX && cycle_done && mix_left != 8'd0) mix_left <= mix_left - 8'd1;
            if (state == PH_SETTLE && reps_left != 4'd0) reps_left <= reps_left - 4'd1;
        end
    end

    always_comb begin
        valves_next       = valve_pattern(state_next);
        valves_next.pump1 = pump_pat[2];
        valves_next.pump2 = pump_pat[1];
        valves_next.pump3 = pump_pat[0];
        busy_next         = (state_next != PH_IDLE);
        done_next         = (state == PH_COLLECT) && timer_end && !bus.abort;
        aborted_next      = (state != PH_IDLE) && bus.abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valves_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            valves_q  <= valves_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
            aborted_q <= aborted_next;
        end
    end

    assign bus.phase          = state;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
    assign bus.lysis_ctl      = valves_q.lysis;
    assign bus.wash_ctl       = valves_q.wash;
    assign bus.elute_ctl      = valves_q.elute;
    assign bus.horiz_ctl      = valves_q.horiz;
    assign bus.vertical_ctl   = valves_q.vertical;
    assign bus.loop_exit_ctl  = valves_q.loop_exit;
    assign bus.bead_vtl_ctl   = valves_q.bead_vtl;
    assign bus.bead_trap_ctl  = valves_q.bead_trap;
    assign bus.collection_ctl = valves_q.collection;
    assign bus.dead_end_ctl   = valves_q.dead_end;
    assign bus.pump1          = valves_q.pump1;
    assign bus.pump2          = valves_q.pump2;
    assign bus.pump3          = valves_q.pump3;
endmodule

// File: tb/tb_nucleic_acid_sequencer.sv
// tb/tb_nucleic_acid_sequencer.sv - scoreboard bench for nucleic_acid_sequencer
module tb_nucleic_acid_sequencer;
    localparam int T_W = 16;

    // {lysis,wash,elute,horiz,vertical,loop_exit,bead_vtl,bead_trap,collection,dead_end,p1,p2,p3}
    localparam logic [12:0] V_NONE  = 13'b0000000000_000;
    localparam logic [12:0] V_LOAD  = 13'b1001100000_000;
    localparam logic [12:0] V_MIX   = 13'b0000100000_100;
    localparam logic [12:0] V_CAP   = 13'b0000011101_000;
    localparam logic [12:0] V_WASH  = 13'b0100110100_000;
    localparam logic [12:0] V_ELUTE = 13'b0010110100_000;
    localparam logic [12:0] V_COLL  = 13'b0000010110_000;
    localparam logic [2:0]  F_RUN   = 3'b100;
    localparam logic [2:0]  F_DONE  = 3'b010;
    localparam logic [2:0]  F_ABORT = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nucleic_acid_sequencer_if #(.T_W(T_W)) bus ();

    nucleic_acid_sequencer #(
        .T_W(T_W), .STEP_TICKS(4), .CAPTURE_TICKS(64), .COLLECT_TICKS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0]  ph;
        int          dur;
        logic [12:0] valves;
        logic [2:0]  flags;
    } ev_t;

    ev_t        exp_q[$];
    logic [2:0] pump_q[$];
    ev_t        e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         load_cyc = 0;
    int         run_len = -1;
    int         cnt = 0;
    logic [2:0] prev_ph = 3'd0;
    logic       exp_busy = 1'b0;
    logic [12:0] obs;

    assign obs = {bus.lysis_ctl, bus.wash_ctl, bus.elute_ctl, bus.horiz_ctl, bus.vertical_ctl,
                  bus.loop_exit_ctl, bus.bead_vtl_ctl, bus.bead_trap_ctl, bus.collection_ctl,
                  bus.dead_end_ctl, bus.pump1, bus.pump2, bus.pump3};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_ev(input logic [2:0] ph, input int dur, input logic [12:0] v, input logic [2:0] f);
        ev_t x;
        x.ph = ph; x.dur = dur; x.valves = v; x.flags = f;
        exp_q.push_back(x);
    endtask

    task automatic push_pumps(input int n);
        for (int c = 0; c < n; c++) begin
            pump_q.push_back(3'b100); pump_q.push_back(3'b110); pump_q.push_back(3'b010);
            pump_q.push_back(3'b011); pump_q.push_back(3'b001); pump_q.push_back(3'b101);
        end
    endtask

    task automatic run_start(input int lt, input int mc, input int wt, input int wr, input int et);
        @(negedge clk);
        bus.load_time  = T_W'(lt);
        bus.mix_cycles = 8'(mc);
        bus.wash_time  = T_W'(wt);
        bus.wash_reps  = 4'(wr);
        bus.elute_time = T_W'(et);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d events pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        check({name, "_pumps_left"}, 32'(pump_q.size()), 32'd0);
        pump_q.delete();
    endtask

    // Monitor: per-cycle invariants, phase-change events against the scoreboard, pump steps.
    always @(negedge clk) begin
        if (rst) begin
            prev_ph  = 3'd0;
            cnt      = 0;
            exp_busy = 1'b0;
        end else begin
            check("inlet_exclusive", 32'($countones(obs[12:10]) <= 1), 32'd1);
            check("collect_vs_wash", 32'(obs[4] & obs[11]), 32'd0);
            if (bus.phase == 3'd2)
                check("pump_mix_legal", 32'(obs[2:0] != 3'b000 && obs[2:0] != 3'b111), 32'd1);
            if (bus.phase != prev_ph) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_phase: got %0d expected no change from %0d", bus.phase, prev_ph);
                end else begin
                    e = exp_q.pop_front();
                    check("phase", 32'(bus.phase), 32'(e.ph));
                    if (e.dur >= 0) check("prev_phase_dur", 32'(cnt), 32'(e.dur));
                    check("valves", 32'(obs), 32'(e.valves));
                    check("busy_done_aborted", 32'({bus.busy, bus.done, bus.aborted}), 32'(e.flags));
                    exp_busy = e.flags[2];
                    if (e.ph == 3'd1) load_cyc = cyc;
                    if (e.flags[1]) run_len = cyc - load_cyc;
                end
                cnt     = 1;
                prev_ph = bus.phase;
            end else begin
                cnt++;
                check("no_stray_pulse", 32'({bus.done, bus.aborted}), 32'd0);
                check("busy_hold", 32'(bus.busy), 32'(exp_busy));
            end
            if (bus.phase == 3'd2 && ((cnt - 1) % 4) == 0) begin
                if (pump_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pump_step: got %b expected no sample", obs[2:0]);
                end else begin
                    check("pump_step", 32'(obs[2:0]), 32'(pump_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.load_time = '0; bus.mix_cycles = '0; bus.wash_time = '0;
        bus.wash_reps = '0; bus.elute_time = '0;
        #1 rst = 1'b1;
        #2;
        check("reset_phase", 32'(bus.phase), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_valves", 32'(obs), 32'd0);
        check("reset_pulses", 32'({bus.done, bus.aborted}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal run
        push_ev(3'd1, -1, V_LOAD,  F_RUN);
        push_ev(3'd2, 10, V_MIX,   F_RUN);
        push_ev(3'd3, 48, V_CAP,   F_RUN);
        push_ev(3'd4, 64, V_WASH,  F_RUN);
        push_ev(3'd5, 5,  V_NONE,  F_RUN);
        push_ev(3'd4, 1,  V_WASH,  F_RUN);
        push_ev(3'd5, 5,  V_NONE,  F_RUN);
        push_ev(3'd6, 1,  V_ELUTE, F_RUN);
        push_ev(3'd7, 8,  V_COLL,  F_RUN);
        push_ev(3'd0, 32, V_NONE,  F_DONE);
        push_pumps(2);
        run_start(10, 2, 5, 2, 8);
        drain("nominal", 400);
        check("nominal_run_len", 32'(run_len), 32'd174);

        // Abort in the third cycle of the second WASH
        push_ev(3'd1, -1, V_LOAD, F_RUN);
        push_ev(3'd2, 3,  V_MIX,  F_RUN);
        push_ev(3'd3, 24, V_CAP,  F_RUN);
        push_ev(3'd4, 64, V_WASH, F_RUN);
        push_ev(3'd5, 5,  V_NONE, F_RUN);
        push_ev(3'd4, 1,  V_WASH, F_RUN);
        push_ev(3'd0, 3,  V_NONE, F_ABORT);
        push_pumps(1);
        run_start(3, 1, 5, 2, 4);
        repeat (99) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        drain("abort", 50);

        // Restart after abort through skip paths: 1-cycle LOAD, no MIX, no WASH
        push_ev(3'd1, -1, V_LOAD,  F_RUN);
        push_ev(3'd3, 1,  V_CAP,   F_RUN);
        push_ev(3'd6, 64, V_ELUTE, F_RUN);
        push_ev(3'd7, 2,  V_COLL,  F_RUN);
        push_ev(3'd0, 32, V_NONE,  F_DONE);
        run_start(0, 0, 5, 0, 2);
        drain("skip", 200);

        // Start with abort in IDLE is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("idle_start_abort_busy", 32'(bus.busy), 32'd0);
        check("idle_start_abort_phase", 32'(bus.phase), 32'd0);
        check("idle_abort_no_pulse", 32'(bus.aborted), 32'd0);
        repeat (3) @(negedge clk);

        // Start and config changes during ELUTE are ignored
        push_ev(3'd1, -1, V_LOAD,  F_RUN);
        push_ev(3'd2, 2,  V_MIX,   F_RUN);
        push_ev(3'd3, 24, V_CAP,   F_RUN);
        push_ev(3'd4, 64, V_WASH,  F_RUN);
        push_ev(3'd5, 3,  V_NONE,  F_RUN);
        push_ev(3'd6, 1,  V_ELUTE, F_RUN);
        push_ev(3'd7, 8,  V_COLL,  F_RUN);
        push_ev(3'd0, 32, V_NONE,  F_DONE);
        push_pumps(1);
        run_start(2, 1, 3, 1, 8);
        repeat (96) @(negedge clk);
        bus.load_time = 16'd7; bus.mix_cycles = 8'd5; bus.wash_time = 16'd9;
        bus.wash_reps = 4'd3;  bus.elute_time = 16'd50;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain("elute_start", 200);

        // Asynchronous reset in the middle of MIX
        push_ev(3'd1, -1, V_LOAD, F_RUN);
        push_ev(3'd2, 2,  V_MIX,  F_RUN);
        push_pumps(2);
        run_start(2, 2, 5, 1, 3);
        repeat (10) @(negedge clk);
        check("pre_reset_events", 32'(exp_q.size()), 32'd0);
        #2 rst = 1'b1;
        exp_q.delete();
        pump_q.delete();
        #1;
        check("async_reset_phase", 32'(bus.phase), 32'd0);
        check("async_reset_busy", 32'(bus.busy), 32'd0);
        check("async_reset_valves", 32'(obs), 32'd0);
        check("async_reset_pulses", 32'({bus.done, bus.aborted}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_phase", 32'(bus.phase), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
